// File: rtl/kbd_ctl.sv
// kbd_ctl: host-side sequencer for the PS/2 keyboard block.
// Boots the keyboard (FF, ACK, BAT), sends LED updates (ED + mask) with ACK
// checking and bounded resend, and buffers ASCII keystrokes in a FWFT FIFO.
module kbd_ctl #(
   parameter int unsigned TIMEOUT = 2500000,
   parameter int unsigned RETRIES = 3,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic               clock,
   input  logic               reset,
   output logic               kb_cmd,
   output logic [7:0]         kb_dat,
   input  logic               kb_ready,
   input  logic               kb_hit,
   input  logic [7:0]         kb_byte,
   input  logic               kb_kdone,
   input  logic [7:0]         kb_ascii,
   input  logic               kb_err,
   input  logic               led_req,
   input  logic [2:0]         led,
   output logic               led_busy,
   input  logic               rd,
   output logic [7:0]         dout,
   output logic               empty,
   output logic [FIFO_AW:0]   count,
   output logic               overflow,
   output logic               online,
   output logic               fault
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

   localparam logic [7:0] B_RESET = 8'hFF;
   localparam logic [7:0] B_LED   = 8'hED;
   localparam logic [7:0] B_ACK   = 8'hFA;
   localparam logic [7:0] B_RESEND = 8'hFE;
   localparam logic [7:0] B_BAT_OK = 8'hAA;
   localparam logic [7:0] B_BAT_ERR = 8'hFC;

   typedef enum logic [2:0] {
      S_BOOT, S_ISSUE, S_WAIT_ACK, S_WAIT_BAT, S_IDLE
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    cmd_byte_q, cmd_byte_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          err_q;
   logic          online_q, online_d;
   logic          fault_q, fault_d;
   logic          pending_q, pending_d;
   logic [2:0]    mask_q, mask_d;
   logic [2:0]    cur_mask_q, cur_mask_d;
   logic          seq_q, seq_d;
   logic          kb_cmd_q, kb_cmd_d;
   logic [7:0]    kb_dat_q, kb_dat_d;

   logic timeout, err_rise, is_ack, is_retry;

   assign timeout  = (timer_q == TW'(TIMEOUT - 1));
   assign err_rise = kb_err & ~err_q;
   assign is_ack   = kb_hit && (kb_byte == B_ACK);

   // Sequencer state and control registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_BOOT;
         cmd_byte_q <= '0;
         retry_q    <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         online_q   <= 1'b0;
         fault_q    <= 1'b0;
         pending_q  <= 1'b0;
         mask_q     <= '0;
         cur_mask_q <= '0;
         seq_q      <= 1'b0;
         kb_cmd_q   <= 1'b0;
         kb_dat_q   <= '0;
      end else begin
         state_q    <= state_d;
         cmd_byte_q <= cmd_byte_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         err_q      <= kb_err;
         online_q   <= online_d;
         fault_q    <= fault_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         cur_mask_q <= cur_mask_d;
         seq_q      <= seq_d;
         kb_cmd_q   <= kb_cmd_d;
         kb_dat_q   <= kb_dat_d;
      end
   end

   // Next-state logic: command issue, ACK/retry handling, LED request latch.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cmd_byte_d = cmd_byte_q;
      retry_d    = retry_q;
      timer_d    = timer_q;
      online_d   = online_q;
      fault_d    = fault_q;
      pending_d  = pending_q;
      mask_d     = mask_q;
      cur_mask_d = cur_mask_q;
      seq_d      = seq_q;
      kb_cmd_d   = 1'b0;
      kb_dat_d   = kb_dat_q;
      is_retry   = 1'b0;

      case (state_q)
         S_BOOT: begin
            cmd_byte_d = B_RESET;
            retry_d    = '0;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            if (kb_ready) begin
               kb_cmd_d = 1'b1;
               kb_dat_d = cmd_byte_q;
               timer_d  = '0;
               state_d  = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            timer_d  = timer_q + 1'b1;
            is_retry = (kb_hit && (kb_byte == B_RESEND)) || err_rise || timeout;
            if (is_ack) begin
               retry_d = '0;
               timer_d = '0;
               if (cmd_byte_q == B_RESET) begin
                  state_d = S_WAIT_BAT;
               end else if (cmd_byte_q == B_LED) begin
                  cmd_byte_d = {5'b0, cur_mask_q};
                  state_d    = S_ISSUE;
               end else begin
                  seq_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end else if (is_retry) begin
               if (retry_q < RW'(RETRIES)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  fault_d  = 1'b1;
                  online_d = 1'b0;
                  seq_d    = 1'b0;
                  state_d  = S_IDLE;
               end
            end
         end
         S_WAIT_BAT: begin
            timer_d = timer_q + 1'b1;
            if (kb_hit && (kb_byte == B_BAT_OK)) begin
               online_d   = 1'b1;
               cmd_byte_d = B_LED;
               cur_mask_d = 3'b000;
               seq_d      = 1'b1;
               retry_d    = '0;
               state_d    = S_ISSUE;
            end else if ((kb_hit && (kb_byte == B_BAT_ERR)) || timeout) begin
               fault_d  = 1'b1;
               online_d = 1'b0;
               seq_d    = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_IDLE: begin
            if (pending_q && online_q) begin
               cmd_byte_d = B_LED;
               cur_mask_d = mask_q;
               pending_d  = 1'b0;
               seq_d      = 1'b1;
               retry_d    = '0;
               state_d    = S_ISSUE;
            end
         end
         default: state_d = S_BOOT;
      endcase

      // A new request always wins over the clear at sequence start.
      if (led_req) begin
         pending_d = 1'b1;
         mask_d    = led;
      end
   end

   assign kb_cmd   = kb_cmd_q;
   assign kb_dat   = kb_dat_q;
   assign led_busy = pending_q | seq_q;
   assign online   = online_q;
   assign fault    = fault_q;

   // ---------------- keystroke FIFO ----------------
   logic [7:0]         mem [0:(1 << FIFO_AW) - 1];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   cnt_q;
   logic               ovf_q;
   logic               accept, full, do_wr, do_rd;

   assign accept = kb_kdone && (state_q != S_WAIT_ACK) && (state_q != S_WAIT_BAT);
   assign full   = (cnt_q == FULL_CNT);
   assign do_rd  = rd && (cnt_q != '0);
   assign do_wr  = accept && (!full || rd);

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (accept && full && !rd) ovf_q <= 1'b1;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clock) begin
      // NOTE: storage is not reset; the pointers and count alone define what is valid.
      if (do_wr) mem[wptr_q] <= kb_ascii;
   end

   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign dout     = empty ? 8'h00 : mem[rptr_q];
   assign overflow = ovf_q;

endmodule

// File: tb/tb_kbd_ctl.sv
// tb_kbd_ctl: self-checking bench for kbd_ctl with a procedural keyboard
// model, a table of FIFO vectors, and a queue-based random FIFO reference.
module tb_kbd_ctl;

   localparam int TO = 100;
   localparam int AW = 4;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset;
   logic          kb_cmd;
   logic [7:0]    kb_dat;
   logic          kb_ready;
   logic          kb_hit;
   logic [7:0]    kb_byte;
   logic          kb_kdone;
   logic [7:0]    kb_ascii;
   logic          kb_err;
   logic          led_req;
   logic [2:0]    led;
   logic          led_busy;
   logic          rd;
   logic [7:0]    dout;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          online;
   logic          fault;

   int checks   = 0;
   int failures = 0;

   kbd_ctl #(.TIMEOUT(TO), .RETRIES(3), .FIFO_AW(AW)) dut (
      .clock(clock), .reset(reset),
      .kb_cmd(kb_cmd), .kb_dat(kb_dat), .kb_ready(kb_ready),
      .kb_hit(kb_hit), .kb_byte(kb_byte), .kb_kdone(kb_kdone),
      .kb_ascii(kb_ascii), .kb_err(kb_err),
      .led_req(led_req), .led(led), .led_busy(led_busy),
      .rd(rd), .dout(dout), .empty(empty), .count(count),
      .overflow(overflow), .online(online), .fault(fault)
   );

   always #20 clock = ~clock;

   typedef struct {
      logic       kdone;
      logic [7:0] ascii;
      logic       rd;
      int         exp_count;
      logic [7:0] exp_dout;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait for the next command strobe and check its byte.
   task automatic wait_cmd(input logic [7:0] exp, input string name);
      for (int i = 0; i < 400; i++) begin
         tick();
         if (kb_cmd === 1'b1) begin
            check({name, " kb_dat"}, {24'h0, kb_dat}, {24'h0, exp});
            return;
         end
      end
      check({name, " strobe timeout"}, 32'd0, 32'd1);
   endtask

   task automatic reply(input logic [7:0] b);
      kb_hit  = 1'b1;
      kb_byte = b;
      tick();
      kb_hit  = 1'b0;
      kb_byte = 8'h00;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " kb_cmd"},   {31'h0, kb_cmd},   32'd0);
      check({tag, " kb_dat"},   {24'h0, kb_dat},   32'd0);
      check({tag, " led_busy"}, {31'h0, led_busy}, 32'd0);
      check({tag, " dout"},     {24'h0, dout},     32'd0);
      check({tag, " empty"},    {31'h0, empty},    32'd1);
      check({tag, " count"},    32'(count),        32'd0);
      check({tag, " overflow"}, {31'h0, overflow}, 32'd0);
      check({tag, " online"},   {31'h0, online},   32'd0);
      check({tag, " fault"},    {31'h0, fault},    32'd0);
   endtask

   task automatic do_boot(input string tag);
      wait_cmd(8'hFF, {tag, " FF"});
      reply(8'hFA);
      check({tag, " online before BAT"}, {31'h0, online}, 32'd0);
      reply(8'hAA);
      check({tag, " online after BAT"}, {31'h0, online}, 32'd1);
      wait_cmd(8'hED, {tag, " ED"});
      reply(8'hFA);
      wait_cmd(8'h00, {tag, " mask 00"});
      reply(8'hFA);
      check({tag, " led_busy done"}, {31'h0, led_busy}, 32'd0);
      check({tag, " fault"}, {31'h0, fault}, 32'd0);
   endtask

   task automatic pulse_led(input logic [2:0] m);
      led_req = 1'b1;
      led     = m;
      tick();
      led_req = 1'b0;
   endtask

   initial begin
      int strobes;
      int stray_strobes;
      logic [7:0] q[$];
      logic model_ovf;

      reset = 1'b1; kb_ready = 1'b1; kb_hit = 1'b0; kb_byte = 8'h00;
      kb_kdone = 1'b0; kb_ascii = 8'h00; kb_err = 1'b0;
      led_req = 1'b0; led = 3'b000; rd = 1'b0;

      // ---- reset state and boot ----
      tick(); tick();
      check_reset_values("reset");
      reset = 1'b0;
      do_boot("boot");

      // ---- LED update 101, keystroke ignored while waiting for ACK ----
      pulse_led(3'b101);
      check("led busy after req", {31'h0, led_busy}, 32'd1);
      wait_cmd(8'hED, "led ED");
      kb_kdone = 1'b1; kb_ascii = 8'h61;
      tick();
      kb_kdone = 1'b0;
      check("kdone ignored in WAIT_ACK", 32'(count), 32'd0);
      check("led busy after ED", {31'h0, led_busy}, 32'd1);
      reply(8'hFA);
      check("led busy between", {31'h0, led_busy}, 32'd1);
      wait_cmd(8'h05, "led mask 05");
      check("led busy before last ACK", {31'h0, led_busy}, 32'd1);
      reply(8'hFA);
      check("led busy cleared", {31'h0, led_busy}, 32'd0);

      // ---- resend twice, plus an overwriting request mid-sequence ----
      pulse_led(3'b010);
      wait_cmd(8'hED, "resend ED#1");
      pulse_led(3'b111);
      reply(8'hFE);
      wait_cmd(8'hED, "resend ED#2");
      reply(8'hFE);
      wait_cmd(8'hED, "resend ED#3");
      reply(8'hFA);
      wait_cmd(8'h02, "resend mask 02");
      reply(8'hFA);
      check("resend fault", {31'h0, fault}, 32'd0);
      check("extra seq pending", {31'h0, led_busy}, 32'd1);
      // extra sequence: kb_err rising edge retries, stray byte ignored
      wait_cmd(8'hED, "extra ED#1");
      kb_err = 1'b1;
      tick();
      kb_err = 1'b0;
      wait_cmd(8'hED, "extra ED#2 after err");
      reply(8'hFA);
      wait_cmd(8'h07, "extra mask 07");
      reply(8'h1C);
      stray_strobes = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (kb_cmd) stray_strobes++;
      end
      check("stray byte no resend", 32'(stray_strobes), 32'd0);
      reply(8'hFA);
      check("extra seq done", {31'h0, led_busy}, 32'd0);
      check("online kept", {31'h0, online}, 32'd1);

      // ---- FIFO table: 17 pushes, combined rd+push, drain, rd at empty ----
      for (int i = 0; i < 17; i++)
         vecs.push_back('{1'b1, 8'(8'h41 + i), 1'b0, (i + 1 > DEPTH) ? DEPTH : i + 1,
                          8'h41, (i >= DEPTH)});
      vecs.push_back('{1'b1, 8'h52, 1'b1, DEPTH, 8'h42, 1'b1});
      for (int k = 1; k <= DEPTH; k++)
         vecs.push_back('{1'b0, 8'h00, 1'b1, DEPTH - k,
                          (k < 15) ? 8'(8'h42 + k) : ((k == 15) ? 8'h52 : 8'h00), 1'b1});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b1});
      foreach (vecs[v]) begin
         kb_kdone = vecs[v].kdone;
         kb_ascii = vecs[v].ascii;
         rd       = vecs[v].rd;
         tick();
         kb_kdone = 1'b0; rd = 1'b0;
         check($sformatf("fifo vec%0d count", v), 32'(count), 32'(vecs[v].exp_count));
         check($sformatf("fifo vec%0d dout", v), {24'h0, dout}, {24'h0, vecs[v].exp_dout});
         check($sformatf("fifo vec%0d empty", v), {31'h0, empty},
               {31'h0, (vecs[v].exp_count == 0)});
         check($sformatf("fifo vec%0d ovf", v), {31'h0, overflow}, {31'h0, vecs[v].exp_ovf});
      end

      // ---- randomized FIFO traffic against a queue reference ----
      q.delete();
      model_ovf = 1'b1;
      for (int c = 0; c < 400; c++) begin
         logic kd, r, was_full;
         logic [7:0] a;
         kd = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 45);
         a  = 8'($urandom);
         kb_kdone = kd; kb_ascii = a; rd = r;
         tick();
         kb_kdone = 1'b0; rd = 1'b0;
         was_full = (q.size() == DEPTH);
         if (kd && was_full && !r) model_ovf = 1'b1;
         if (r && q.size() > 0) void'(q.pop_front());
         if (kd && (!was_full || r)) q.push_back(a);
         check($sformatf("rand%0d count", c), 32'(count), 32'(q.size()));
         check($sformatf("rand%0d dout", c), {24'h0, dout},
               {24'h0, (q.size() > 0) ? q[0] : 8'h00});
         check($sformatf("rand%0d ovf", c), {31'h0, overflow}, {31'h0, model_ovf});
      end

      // ---- reset between ED ACK and mask issue ----
      pulse_led(3'b011);
      wait_cmd(8'hED, "midreset ED");
      reply(8'hFA);
      reset = 1'b1;
      tick();
      check_reset_values("midreset");
      reset = 1'b0;
      do_boot("reboot");

      // ---- fault: keyboard never replies ----
      reset = 1'b1;
      tick();
      reset = 1'b0;
      strobes = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (kb_cmd) begin
            strobes++;
            check("fault strobe byte", {24'h0, kb_dat}, 32'h0000_00FF);
         end
      end
      check("fault FF strobes", 32'(strobes), 32'd4);
      check("fault flag", {31'h0, fault}, 32'd1);
      check("fault online", {31'h0, online}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_ctl.md
Name: kbd_ctl

Overview:
- Host-side sequencer for the PS/2 keyboard interface block.
- After reset it issues the keyboard reset command and confirms the self-test reply.
- It then owns the command channel: it sends LED-update sequences (ED + mask), checks each ACK, and retries on resend or error.
- It also buffers decoded ASCII keystrokes in a FIFO so the CPU side can read them at its own pace.

Parameters:
- TIMEOUT, 2500000: clock cycles to wait for a keyboard reply byte (100 ms at 25 MHz).
- RETRIES, 3: maximum resend attempts per command byte before declaring a fault.
- FIFO_AW, 4: FIFO address width; depth is 2^FIFO_AW.

Ports:
- clock, in, 1: 25 MHz system clock, single domain.
- reset, in, 1: synchronous, active-high.
- kb_cmd, out, 1: one-cycle strobe to the keyboard block's command input.
- kb_dat, out, 8: command byte; valid in the same cycle as kb_cmd.
- kb_ready, in, 1: keyboard block is idle and accepts a command.
- kb_hit, in, 1: one-cycle pulse; a valid byte arrived on kb_byte.
- kb_byte, in, 8: last received raw byte.
- kb_kdone, in, 1: one-cycle pulse; an ASCII key-down arrived on kb_ascii.
- kb_ascii, in, 8: decoded character.
- kb_err, in, 1: keyboard block error or timeout flag (level).
- led_req, in, 1: one-cycle request to update LEDs.
- led, in, 3: {caps, num, scroll} mask; sampled while led_req=1.
- led_busy, out, 1: an LED sequence is pending or in progress.
- rd, in, 1: FIFO pop; dout advances on the next cycle.
- dout, out, 8: FIFO head (first-word-fall-through).
- empty, out, 1: FIFO empty.
- count, out, FIFO_AW+1: FIFO occupancy.
- overflow, out, 1: sticky; set when a keystroke is dropped.
- online, out, 1: keyboard passed BAT and is usable.
- fault, out, 1: sticky; retries were exhausted.

Behaviour:
- Reset values: kb_cmd=0, kb_dat=0, led_busy=0, dout=0, empty=1, count=0, overflow=0, online=0, fault=0.
- Reset clears the FIFO, the pending LED request, and all counters. Reset mid-sequence abandons the sequence; no strobe is emitted in the reset cycle.
- FSM states:
  - BOOT: load byte=FF, go to ISSUE.
  - ISSUE: wait for kb_ready=1, then pulse kb_cmd for 1 cycle with kb_dat=byte. Clear the timeout counter and go to WAIT_ACK.
  - WAIT_ACK: on kb_hit with kb_byte:
    - FA: go to the next step.
    - FE: retry.
    - Any other byte: ignored (stray scancode); the timer keeps running.
  - WAIT_ACK: kb_err rising edge, or the timer reaching TIMEOUT-1, counts as a retry.
  - Retry: if retry_cnt < RETRIES, increment it and go to ISSUE with the same byte. Otherwise set fault=1 and online=0, drop the current sequence, and go to IDLE.
  - WAIT_BAT (after the FF ACK): kb_hit with AA sets online=1, then the controller performs an LED sequence with mask 000. kb_byte FC or timeout leads to the fault path (no retry).
  - IDLE: if an LED request is pending and online=1, load byte=ED and go to ISSUE. After the ED ACK, load byte={5'b0, led_mask} and go to ISSUE; after that ACK, clear pending and return to IDLE.
- retry_cnt resets to 0 at each new command byte.
- LED pending register:
  - led_req latches the mask and sets pending; led_busy = pending | sequence active.
  - led_req during an active sequence overwrites the latched mask; it is applied after the current sequence completes (one extra sequence).
  - led_req while online=0 is latched and served once online.
- fault is cleared only by reset.
- Keystrokes are ignored while the FSM is in WAIT_ACK or WAIT_BAT; the keyboard block does not raise kdone for FA/FE/AA.
- FIFO rules:
  - Write occurs on kb_kdone when count < depth, or when count = depth and rd=1 in the same cycle.
  - Full with no rd: the byte is dropped and overflow=1.
  - rd while empty: ignored.
  - Simultaneous write and read: count unchanged.
  - Pointers wrap modulo depth; count saturates at 0 and depth by construction.
- Timeout counter width is ceil(log2(TIMEOUT)); it counts only in WAIT_ACK and WAIT_BAT.

Test Plan:
- Boot: release reset with the keyboard model ready. Expect kb_cmd with FF. Model replies FA, then AA. Expect online=1, then ED sent, FA, 00 sent, FA, led_busy=0.
- LED update: led_req with led=101 when online. Expect ED, then 05 strobes, each waiting for FA. led_busy stays 1 until the second FA.
- Resend: reply FE to ED twice, then FA. Expect ED sent 3 times total, fault=0, sequence completes.
- Fault: never reply (TIMEOUT=100 in the bench). Expect FF sent 4 times, then fault=1, online=0, no further kb_cmd.
- FIFO: with depth=16, push 17 kdone pulses (ascii 41..51) with no rd. Expect count=16, overflow=1, dout=41. Then assert rd+kdone together: count stays 16 and dout=42.
- Reset mid-sequence: assert reset between ED ACK and mask issue. Expect all outputs at reset values and the BOOT sequence restarting with FF.
